// File: rtl/tsc_pretrig.sv
// tsc_pretrig: transient capture core with pre-trigger ring buffer,
// edge-selectable threshold trigger, timestamp and serial readout.
module tsc_pretrig #(
  parameter int DW    = 8,
  parameter int DEPTH = 32,
  parameter int PRE   = 16,
  parameter int CDW   = 32
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic           SBF,
  input  logic [DW-1:0]  thresh,
  input  logic           edge_sel,
  input  logic           rdy,
  input  logic [DW-1:0]  dat,
  output logic           req,
  output logic           rst,
  output logic [CDW-1:0] CD,
  output logic           TRD,
  output logic           SD,
  output logic           SBUSY
);

  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int BW   = (DW > 1) ? $clog2(DW) : 1;
  localparam int FW   = $clog2(PRE + 1);
  localparam int POST = DEPTH - PRE - 1;

  localparam logic [FW-1:0] PREC  = FW'(PRE);
  localparam logic [AW-1:0] PLAST = AW'(POST - 1);
  localparam logic [AW-1:0] SLAST = AW'(DEPTH - 1);
  localparam logic [BW-1:0] BTOP  = BW'(DW - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    RUNNING   = 2'b01,
    TRIGGERED = 2'b10,
    BUFSEND   = 2'b11
  } state_t;

  state_t st, nx;

  logic [DW-1:0]  mem [DEPTH];
  logic [AW-1:0]  wptr, tptr, rptr;
  logic [AW-1:0]  post, scnt;
  logic [FW-1:0]  fill;
  logic [BW-1:0]  bidx;
  logic [DW-1:0]  prev;
  logic           pv;
  logic [CDW-1:0] timer;

  logic acc, armed, xing, hit;
  logic last_post, last_frame, go_send;

  assign acc   = req & rdy;
  assign armed = pv & (fill == PREC);
  assign xing  = edge_sel ? ((prev >= thresh) && (dat < thresh))
                          : ((prev < thresh) && (dat >= thresh));
  assign hit   = acc & armed & xing;

  assign last_post  = acc & (post == PLAST);
  assign last_frame = (bidx == '0) & (scnt == SLAST);
  assign go_send    = ~start & SBF & TRD;

  always_comb begin
    nx = st;
    unique case (st)
      IDLE: begin
        if (start)        nx = RUNNING;
        else if (go_send) nx = BUFSEND;
      end
      RUNNING: begin
        if (hit) nx = (POST == 0) ? IDLE : TRIGGERED;
      end
      TRIGGERED: begin
        if (last_post) nx = IDLE;
      end
      BUFSEND: begin
        if (last_frame) nx = IDLE;
      end
      default: nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    rst <= reset;
    if (reset) begin
      st    <= IDLE;
      req   <= 1'b0;
      CD    <= '0;
      TRD   <= 1'b0;
      timer <= '0;
      wptr  <= '0;
      tptr  <= '0;
      rptr  <= '0;
      post  <= '0;
      scnt  <= '0;
      fill  <= '0;
      bidx  <= '0;
      prev  <= '0;
      pv    <= 1'b0;
    end else begin
      st    <= nx;
      timer <= timer + CDW'(1);
      req   <= (nx == RUNNING) || (nx == TRIGGERED);
      if (st == IDLE && start) begin
        TRD  <= 1'b0;
        fill <= '0;
        pv   <= 1'b0;
      end
      if (acc) begin
        wptr <= wptr + AW'(1);
        prev <= dat;
        pv   <= 1'b1;
        if (fill != PREC) fill <= fill + FW'(1);
      end
      // timestamp is the timer value seen on the accepting edge
      if (st == RUNNING && hit) begin
        TRD  <= 1'b1;
        CD   <= timer;
        tptr <= wptr;
        post <= '0;
      end
      if (st == TRIGGERED && acc) post <= post + AW'(1);
      if (st == IDLE && go_send) begin
        rptr <= tptr - AW'(PRE);
        bidx <= BTOP;
        scnt <= '0;
      end
      if (st == BUFSEND) begin
        if (bidx == '0) begin
          bidx <= BTOP;
          rptr <= rptr + AW'(1);
          scnt <= scnt + AW'(1);
        end else begin
          bidx <= bidx - BW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (acc && !reset) mem[wptr] <= dat;
  end

  assign SBUSY = (st == BUFSEND);
  assign SD    = SBUSY & mem[rptr][bidx];

endmodule

// File: tb/tb_tsc_pretrig.sv
// tb_tsc_pretrig: scoreboard bench for tsc_pretrig; expected triggers
// and frame bits are queued at stimulus time, a monitor pops them.
module tb_tsc_pretrig;

  localparam int DW    = 8;
  localparam int DEPTH = 32;
  localparam int PRE   = 16;
  localparam int CDW   = 32;
  localparam int POST  = DEPTH - PRE - 1;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           start = 1'b0;
  logic           sbf = 1'b0;
  logic           edge_sel = 1'b0;
  logic           rdy = 1'b0;
  logic [DW-1:0]  thresh = 8'h80;
  logic [DW-1:0]  dat = '0;
  logic           req, rst, trd, sd, sbusy;
  logic [CDW-1:0] cd;

  tsc_pretrig #(.DW(DW), .DEPTH(DEPTH), .PRE(PRE), .CDW(CDW)) dut (
    .clk(clk), .reset(reset), .start(start), .SBF(sbf),
    .thresh(thresh), .edge_sel(edge_sel), .rdy(rdy), .dat(dat),
    .req(req), .rst(rst), .CD(cd), .TRD(trd), .SD(sd), .SBUSY(sbusy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [CDW-1:0] tmr = '0;
  int unsigned    ecnt = 0;
  always @(posedge clk) begin
    ecnt <= ecnt + 1;
    tmr  <= reset ? '0 : tmr + 32'd1;
  end

  typedef struct {
    logic [CDW-1:0] cd;
    int unsigned    edge_n;
  } trig_t;

  trig_t          tq[$];
  bit             bq[$];
  logic [DW-1:0]  acc[$];
  logic [DW-1:0]  stim[$];
  logic [DW-1:0]  frame[DEPTH];
  bit             mtrd = 1'b0;
  logic [CDW-1:0] mcd = '0;
  logic           trd_q = 1'b0;
  trig_t          tm;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit crossing(input logic [DW-1:0] p,
                                  input logic [DW-1:0] c);
    if (edge_sel) return (p >= thresh) && (c < thresh);
    return (p < thresh) && (c >= thresh);
  endfunction

  // monitor: serial bits while SBUSY, trigger record on TRD rise
  always @(negedge clk) begin
    if (sbusy === 1'b1) begin
      checks++;
      if (bq.size() == 0) begin
        errors++;
        $display("FAIL sbusy_extra act=1 exp=0 t=%0t", $time);
      end else if (sd !== bq[0]) begin
        errors++;
        $display("FAIL sd act=%0b exp=%0b t=%0t", sd, bq[0], $time);
        void'(bq.pop_front());
      end else begin
        void'(bq.pop_front());
      end
    end
    if (trd === 1'b1 && trd_q !== 1'b1) begin
      if (tq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL trig_unexpected act=1 exp=0 t=%0t", $time);
      end else begin
        tm = tq.pop_front();
        chk("cd", cd, tm.cd);
        chk("trig_edge", ecnt, tm.edge_n);
      end
    end
    trd_q = trd;
  end

  task automatic do_reset(input int n);
    @(negedge clk);
    reset = 1'b1; start = 1'b0; sbf = 1'b0; rdy = 1'b0;
    repeat (n) begin
      @(negedge clk);
      chk("rst_req", req, 0);
      chk("rst_trd", trd, 0);
      chk("rst_sd", sd, 0);
      chk("rst_sbusy", sbusy, 0);
      chk("rst_cd", cd, 0);
      chk("rst_out", rst, 1);
    end
    reset = 1'b0;
    bq.delete(); tq.delete(); mtrd = 1'b0;
    @(negedge clk);
    chk("rst_release", rst, 0);
  endtask

  task automatic do_capture(input int rmode, input bit with_sbf);
    int k = 0;
    int trig = -1;
    bit cap = 1'b1;
    bit r;
    int i;
    logic [DW-1:0] d;
    @(negedge clk);
    start = 1'b1; sbf = with_sbf;
    @(negedge clk);
    start = 1'b0; sbf = 1'b0; mtrd = 1'b0;
    acc.delete();
    chk("req_on", req, 1);
    for (int c = 0; c < 3000 && cap; c++) begin
      case (rmode)
        0:       r = 1'b1;
        1:       r = (c % 2 == 0);
        default: r = 1'($urandom_range(0, 1));
      endcase
      if (k < stim.size())                   d = stim[k];
      else if (acc.size() > 60 && trig < 0)  d = (acc.size() % 2) ? 8'hFF : 8'h00;
      else                                   d = 8'($urandom);
      rdy = r;
      dat = r ? d : 8'($urandom);
      if (r) begin
        acc.push_back(d);
        k++;
        i = acc.size() - 1;
        if (trig < 0) begin
          if (i >= PRE && crossing(acc[i-1], d)) begin
            trig = i;
            mcd  = tmr;
            tq.push_back('{tmr, ecnt + 1});
          end
        end else if (i - trig == POST) begin
          cap = 1'b0;
        end
      end
      @(negedge clk);
    end
    rdy = 1'b0;
    chk("req_drop", req, 0);
    chk("trd_set", trd, 1);
    chk("cd_hold", cd, mcd);
    chk("trig_seen", tq.size(), 0);
    if (trig >= PRE) begin
      for (int j = 0; j < DEPTH; j++) frame[j] = acc[trig-PRE+j];
      mtrd = 1'b1;
    end
  endtask

  task automatic push_frame();
    if (mtrd)
      for (int j = 0; j < DEPTH; j++)
        for (int b = DW - 1; b >= 0; b--) bq.push_back(frame[j][b]);
  endtask

  task automatic do_send();
    @(negedge clk);
    sbf = 1'b1;
    push_frame();
    @(negedge clk);
    sbf = 1'b0;
    repeat (DEPTH * DW + 3) @(negedge clk);
    chk("frame_left", bq.size(), 0);
    chk("sd_idle", sd, 0);
    chk("sbusy_idle", sbusy, 0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset(2);

    thresh = 8'h80; edge_sel = 1'b0;
    stim.delete();
    repeat (20) stim.push_back(8'h00);
    stim.push_back(8'hD6);
    repeat (15) stim.push_back(8'h00);
    do_capture(0, 1'b0);
    do_send();
    do_send();

    @(negedge clk);
    rdy = 1'b1; dat = 8'hD6;
    repeat (3) @(negedge clk);
    rdy = 1'b0;
    stim.delete();
    repeat (5) stim.push_back(8'h00);
    stim.push_back(8'hD6);
    repeat (12) stim.push_back(8'h00);
    stim.push_back(8'hD6);
    repeat (15) stim.push_back(8'h00);
    do_capture(1, 1'b0);
    do_send();

    edge_sel = 1'b1;
    stim.delete();
    repeat (20) stim.push_back(8'hFF);
    repeat (16) stim.push_back(8'h10);
    do_capture(0, 1'b0);
    do_send();

    @(negedge clk);
    sbf = 1'b1;
    push_frame();
    @(negedge clk);
    sbf = 1'b0;
    repeat (39) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    bq.delete(); tq.delete(); mtrd = 1'b0;
    chk("mid_sbusy", sbusy, 0);
    chk("mid_trd", trd, 0);
    chk("mid_rst", rst, 1);

    do_send();

    edge_sel = 1'b0;
    stim.delete();
    do_capture(2, 1'b0);
    do_capture(0, 1'b1);
    do_send();

    for (int n = 0; n < 5; n++) begin
      thresh   = 8'($urandom_range(1, 255));
      edge_sel = 1'($urandom_range(0, 1));
      stim.delete();
      do_capture(2, 1'b0);
      do_send();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
